// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core load/store stage vs external requester, with read-return tagging.
// Optional DMEM_ARB_PERF_EN adds saturating conflict/stall counters.
module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);
  localparam logic [BW-1:0] ONE_B = BW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CORE = 2'd1;
  localparam logic [1:0] ST_EXT  = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_EXT  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic [1:0]    rd_owner, rd_owner_nxt;
  logic          gnt_core, gnt_ext;

  always_comb begin
    gnt_core = 1'b0;
    gnt_ext  = 1'b0;
    case ({core_req, ext_req})
      2'b10: gnt_core = 1'b1;
      2'b01: gnt_ext  = 1'b1;
      2'b11: begin
        case (state)
          ST_CORE: gnt_ext = 1'b1;
          ST_EXT: begin
            if (burst_cnt < MAX_B) gnt_ext  = 1'b1;
            else                   gnt_core = 1'b1;
          end
          default: gnt_core = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = gnt_core ? ST_CORE : (gnt_ext ? ST_EXT : ST_IDLE);
    burst_nxt = '0;
    if (gnt_ext) begin
      if (state != ST_EXT)       burst_nxt = ONE_B;
      else if (burst_cnt == MAX_B) burst_nxt = burst_cnt;
      else                       burst_nxt = burst_cnt + ONE_B;
    end
    rd_owner_nxt = OWN_NONE;
    if (gnt_core && !core_we)    rd_owner_nxt = OWN_CORE;
    else if (gnt_ext && !ext_we) rd_owner_nxt = OWN_EXT;
  end

  always_comb begin
    wr      = (gnt_core & core_we) | (gnt_ext & ext_we);
    rd      = (gnt_core & ~core_we) | (gnt_ext & ~ext_we);
    addr    = '0;
    wr_data = '0;
    if (gnt_core) begin
      addr    = core_addr;
      wr_data = core_wdata;
    end else if (gnt_ext) begin
      addr    = ext_addr;
      wr_data = ext_wdata;
    end
  end

  assign ext_gnt     = gnt_ext;
  assign core_stall  = core_req & ~gnt_core;
  // Read data is steered by the tag captured when the read was issued.
  assign core_rvalid = (rd_owner == OWN_CORE);
  assign ext_rvalid  = (rd_owner == OWN_EXT);
  assign core_rdata  = core_rvalid ? rd_data : '0;
  assign ext_rdata   = ext_rvalid ? rd_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      rd_owner  <= OWN_NONE;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      rd_owner  <= rd_owner_nxt;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (core_req && ext_req && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 16'd1;
      if (core_stall && stall_cnt != '1)             stall_cnt    <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          core_req = 1'b0, core_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0] core_addr = '0, ext_addr = '0;
  logic [DW-1:0] core_wdata = '0, ext_wdata = '0;
  logic          core_stall, core_rvalid, ext_gnt, ext_rvalid, wr, rd;
  logic [DW-1:0] core_rdata, ext_rdata, wr_data;
  logic [DW-1:0] rd_data = '0;
  logic [AW-1:0] addr;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0]   conflict_cnt, stall_cnt;
`endif

  logic [DW-1:0] tb_mem [512];
  logic [DW-1:0] ref_mem [16];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
`ifdef DMEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Single-port memory: data for a read appears the cycle after rd.
  always @(posedge clk) begin
    if (pre_en) tb_mem[pre_addr] <= pre_data;
    else if (wr) tb_mem[addr] <= wr_data;
    if (rd) rd_data <= tb_mem[addr];
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ext_req  = 1'b0; ext_we  = 1'b0; ext_addr  = '0; ext_wdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    tick();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk); reset = 1'b0;
    #1;
    tests++;
    if ({core_rvalid, ext_rvalid, wr, rd, ext_gnt, core_stall, addr, wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rv=%b/%b wr=%b rd=%b gnt=%b stall=%b addr=%h wd=%h, want all 0",
               core_rvalid, ext_rvalid, wr, rd, ext_gnt, core_stall, addr, wr_data);
    end
    @(negedge clk); reset = 1'b1;
    tick();
  endtask

  task automatic test_core_read();
    do_reset();
    preload(9'h010, 32'hDEADBEEF);
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'h010;
    @(negedge clk);
    tests++;
    if ({rd, wr, addr, core_stall} !== {1'b1, 1'b0, 9'h010, 1'b0}) begin
      fails++;
      $display("FAIL core_read_issue: rd=%b wr=%b addr=%h stall=%b, want rd=1 wr=0 addr=010 stall=0",
               rd, wr, addr, core_stall);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    tests++;
    if ({core_rvalid, core_rdata, ext_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      fails++;
      $display("FAIL core_read_return: rvalid=%b rdata=%h ext_rvalid=%b, want 1 DEADBEEF 0",
               core_rvalid, core_rdata, ext_rvalid);
    end
    tick();
  endtask

  task automatic test_dual_write();
    do_reset();
    core_req = 1'b1; core_we = 1'b1; core_addr = 9'h030; core_wdata = 32'hA5A5_0001;
    ext_req  = 1'b1; ext_we  = 1'b1; ext_addr  = 9'h031; ext_wdata  = 32'h5A5A_0002;
    @(negedge clk);
    tests++;
    if ({wr, rd, ext_gnt, core_stall, addr, wr_data} !== {4'b1000, 9'h030, 32'hA5A5_0001}) begin
      fails++;
      $display("FAIL dual_write_c0: wr=%b rd=%b gnt=%b stall=%b addr=%h wd=%h, want core write 030",
               wr, rd, ext_gnt, core_stall, addr, wr_data);
    end
    tick();
    core_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({wr, rd, ext_gnt, core_stall, addr, wr_data, core_rvalid, ext_rvalid} !==
        {4'b1010, 9'h031, 32'h5A5A_0002, 2'b00}) begin
      fails++;
      $display("FAIL dual_write_c1: wr=%b rd=%b gnt=%b stall=%b addr=%h wd=%h rv=%b/%b, want ext write 031",
               wr, rd, ext_gnt, core_stall, addr, wr_data, core_rvalid, ext_rvalid);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_burst();
    bit exp_ext [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    do_reset();
    core_req = 1'b1; core_we = 1'b1; core_addr = 9'h040;
    ext_req  = 1'b1; ext_we  = 1'b1; ext_addr  = 9'h041;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({ext_gnt, core_stall, wr} !== {exp_ext[i], exp_ext[i], 1'b1}) begin
        fails++;
        $display("FAIL burst_cycle%0d: gnt=%b stall=%b wr=%b, want gnt=%b stall=%b wr=1",
                 i, ext_gnt, core_stall, wr, exp_ext[i], exp_ext[i]);
      end
      tick();
    end
`ifdef DMEM_ARB_PERF_EN
    idle_inputs();
    @(negedge clk);
    tests++;
    if ({conflict_cnt, stall_cnt} !== {16'd10, 16'd8}) begin
      fails++;
      $display("FAIL perf_counts: conflict=%0d stall=%0d, want 10 8", conflict_cnt, stall_cnt);
    end
    tick();
`endif
    idle_inputs();
  endtask

  task automatic test_alternating_reads();
    do_reset();
    preload(9'h005, 32'h11);
    preload(9'h006, 32'h22);
    core_req = 1'b1; core_addr = 9'h005;
    @(negedge clk);
    tests++;
    if ({rd, addr, ext_gnt} !== {1'b1, 9'h005, 1'b0}) begin
      fails++;
      $display("FAIL alt_core_issue: rd=%b addr=%h gnt=%b, want 1 005 0", rd, addr, ext_gnt);
    end
    tick();
    idle_inputs();
    ext_req = 1'b1; ext_addr = 9'h006;
    @(negedge clk);
    tests++;
    if ({core_rvalid, core_rdata, ext_rvalid, ext_rdata, ext_gnt, rd, addr} !==
        {1'b1, 32'h11, 1'b0, 32'h0, 1'b1, 1'b1, 9'h006}) begin
      fails++;
      $display("FAIL alt_core_return: crv=%b crd=%h erv=%b erd=%h gnt=%b rd=%b addr=%h, want 1 11 0 0 1 1 006",
               core_rvalid, core_rdata, ext_rvalid, ext_rdata, ext_gnt, rd, addr);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    tests++;
    if ({core_rvalid, core_rdata, ext_rvalid, ext_rdata} !== {1'b0, 32'h0, 1'b1, 32'h22}) begin
      fails++;
      $display("FAIL alt_ext_return: crv=%b crd=%h erv=%b erd=%h, want 0 0 1 22",
               core_rvalid, core_rdata, ext_rvalid, ext_rdata);
    end
    tick();
  endtask

  task automatic test_reset_midread();
    do_reset();
    preload(9'h020, 32'hCAFEF00D);
    ext_req = 1'b1; ext_addr = 9'h020;
    @(negedge clk);
    tests++;
    if ({ext_gnt, rd} !== 2'b11) begin
      fails++;
      $display("FAIL midread_issue: gnt=%b rd=%b, want 1 1", ext_gnt, rd);
    end
    idle_inputs();
    reset = 1'b0;
    tick();
    tests++;
    if ({ext_rvalid, core_rvalid, ext_rdata} !== {2'b00, 32'h0}) begin
      fails++;
      $display("FAIL midread_dropped: erv=%b crv=%b erd=%h, want 0 0 0", ext_rvalid, core_rvalid, ext_rdata);
    end
    @(negedge clk); reset = 1'b1;
    tick();
    core_req = 1'b1; core_addr = 9'h020;
    ext_req  = 1'b1; ext_addr  = 9'h021;
    @(negedge clk);
    tests++;
    if ({core_stall, ext_gnt, ext_rvalid, addr} !== {3'b000, 9'h020}) begin
      fails++;
      $display("FAIL midread_idle_grant: stall=%b gnt=%b erv=%b addr=%h, want core granted at 020",
               core_stall, ext_gnt, ext_rvalid, addr);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  // Reference model: each cycle the grant follows the priority rules from the previous owner
  // and the length of the current external run; reads return from a model-owned memory.
  task automatic test_random();
    logic          c_pend = 1'b0, c_we = 1'b0, e_pend = 1'b0, e_we = 1'b0;
    logic [AW-1:0] c_addr = '0, e_addr = '0;
    logic [DW-1:0] c_wd = '0, e_wd = '0, pend_data = '0;
    int            last = 0, run = 0, pend_own = 0, g;
    logic          x_wr, x_rd;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wd, x_crd, x_erd;
    do_reset();
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      preload(AW'(a), ref_mem[a]);
    end
    for (int i = 0; i < 400; i++) begin
      if (!c_pend && $urandom_range(0, 3) != 0) begin
        c_pend = 1'b1; c_we = 1'($urandom_range(0, 1)); c_addr = AW'($urandom_range(0, 15)); c_wd = $urandom;
      end
      if (!e_pend && $urandom_range(0, 1) != 0) begin
        e_pend = 1'b1; e_we = 1'($urandom_range(0, 1)); e_addr = AW'($urandom_range(0, 15)); e_wd = $urandom;
      end
      core_req = c_pend; core_we = c_we; core_addr = c_addr; core_wdata = c_wd;
      ext_req  = e_pend; ext_we  = e_we; ext_addr  = e_addr; ext_wdata  = e_wd;
      if (c_pend && e_pend) g = (last == 0) ? 1 : (last == 1) ? 2 : (run < MB ? 2 : 1);
      else g = c_pend ? 1 : (e_pend ? 2 : 0);
      x_wr   = (g == 1) ? c_we  : (g == 2) ? e_we  : 1'b0;
      x_rd   = (g == 1) ? !c_we : (g == 2) ? !e_we : 1'b0;
      x_addr = (g == 1) ? c_addr : (g == 2) ? e_addr : '0;
      x_wd   = (g == 1) ? c_wd   : (g == 2) ? e_wd   : '0;
      x_crd  = (pend_own == 1) ? pend_data : '0;
      x_erd  = (pend_own == 2) ? pend_data : '0;
      @(negedge clk);
      tests++;
      if ({ext_gnt, core_stall, wr, rd, addr, wr_data, core_rvalid, core_rdata, ext_rvalid, ext_rdata} !==
          {(g == 2), (c_pend && g != 1), x_wr, x_rd, x_addr, x_wd, (pend_own == 1), x_crd, (pend_own == 2), x_erd}) begin
        fails++;
        $display("FAIL random_cycle%0d: gnt=%b stall=%b wr=%b rd=%b addr=%h wd=%h crv=%b crd=%h erv=%b erd=%h | want gnt=%b stall=%b wr=%b rd=%b addr=%h wd=%h crv=%b crd=%h erv=%b erd=%h",
                 i, ext_gnt, core_stall, wr, rd, addr, wr_data, core_rvalid, core_rdata, ext_rvalid, ext_rdata,
                 (g == 2), (c_pend && g != 1), x_wr, x_rd, x_addr, x_wd, (pend_own == 1), x_crd, (pend_own == 2), x_erd);
      end
      pend_own = x_rd ? g : 0;
      pend_data = ref_mem[x_addr[3:0]];
      if (x_wr) ref_mem[x_addr[3:0]] = x_wd;
      if (g == 1) c_pend = 1'b0;
      if (g == 2) e_pend = 1'b0;
      run  = (g == 2) ? ((last == 2) ? (run < MB ? run + 1 : MB) : 1) : 0;
      last = g;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_dual_write();
    test_burst();
    test_alternating_reads();
    test_reset_midread();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, tests=%0d", tests);
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (wr/rd/addr/wr_data/rd_data) between the core's load/store stage and an external requester (program loader / debug port).
- Grants one access per cycle and stalls the core while it is not granted.
- Tags each read so its data returns to the right requester.
- Sits between the datapath memory stage and the data memory.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 9, word address width of data memory.
- MAX_BURST, 4, max consecutive ext grants while core is waiting (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core requests an access this cycle.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_stall  out  1  core_req high and core not granted.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DATA_W  core read data.
- ext_req  in  1  external requests an access.
- ext_we  in  1  external write enable.
- ext_addr  in  ADDR_W  external address.
- ext_wdata  in  DATA_W  external write data.
- ext_gnt  out  1  external access accepted this cycle.
- ext_rvalid  out  1  external read data valid.
- ext_rdata  out  DATA_W  external read data.
- wr  out  1  memory write strobe.
- rd  out  1  memory read strobe.
- addr  out  ADDR_W  memory address.
- wr_data  out  DATA_W  memory write data.
- rd_data  in  DATA_W  memory read data, valid the cycle after rd.

Behaviour:
- FSM, state = owner of the previous cycle's grant:
  - IDLE: no grant last cycle.
  - CORE: core granted last cycle.
  - EXT: external granted last cycle.
- Grant decision is combinational from the registered state and the current requests:
  - Only core_req: grant core.
  - Only ext_req: grant ext.
  - Neither: no grant; next state IDLE.
  - Both, state IDLE: grant core.
  - Both, state CORE: grant ext.
  - Both, state EXT: grant ext if burst_cnt < MAX_BURST, else core.
- Next state = granted owner, or IDLE when nothing is granted.
- burst_cnt:
  - Set to 1 on entering EXT.
  - Increments on each further consecutive ext grant, saturating at MAX_BURST.
  - Cleared to 0 whenever the grant is not ext.
  - Width clog2(MAX_BURST+1).
- Memory drive (combinational, same cycle as grant):
  - addr and wr_data are muxed from the granted requester.
  - wr = granted & we.
  - rd = granted & ~we.
  - No grant: wr = rd = 0, addr = 0, wr_data = 0.
- Handshakes:
  - ext_gnt = ext granted.
  - core_stall = core_req & ~core granted.
  - A requester holds its request stable until granted.
- Read return:
  - Registered tag rd_owner{none, core, ext} is captured each cycle a read is issued.
  - Next cycle, the tagged requester's rvalid pulses high for exactly one cycle, and its rdata = rd_data.
  - The other requester's rdata is 0.
  - Read latency is 1 cycle after grant.
  - Back-to-back reads from alternating owners each return correctly.
- Writes produce no rvalid.
- Reset (async assert, any cycle, including mid-burst or with a read in flight):
  - state = IDLE, burst_cnt = 0, rd_owner = none.
  - core_rvalid = ext_rvalid = 0; an in-flight read is dropped.
  - Combinational outputs follow the reset state.
- Release is synchronous to clk.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs conflict_cnt [15:0], counting cycles with core_req & ext_req both high.
  - Adds outputs stall_cnt [15:0], counting cycles with core_stall high.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; arbitration behaviour identical either way.

Test Plan:
- After reset, core read addr 9'h010, mem holds 32'hDEADBEEF → rd=1 and addr=010 in cycle 0; core_rvalid=1 with core_rdata=DEADBEEF in cycle 1; core_stall=0.
- From IDLE, core write and ext write requested simultaneously → cycle 0 core (wr=1), cycle 1 ext (ext_gnt=1); core_stall=0 throughout.
- Core held at a CORE grant, ext_req held continuously, MAX_BURST=4 → order core, ext ×4, core, ext ×4; core_stall high during ext cycles.
- Alternating reads core@0x005 then ext@0x006 (mem 0x11, 0x22) → core_rvalid with 0x11, then ext_rvalid with 0x22 the following cycle; no cross-delivery.
- Assert reset the cycle after an ext read grant → ext_rvalid stays 0; after release, first request is granted from IDLE.
- DMEM_ARB_PERF_EN defined, 10 cycles of dual requests → conflict_cnt = 10, stall_cnt = number of core-stalled cycles (8 for MAX_BURST=4 starting in IDLE).
